sap1_datapath: RTL and testbench
================================

# sap1_datapath

Execution datapath of the SAP-1 computer and the consumer of the 12-bit control word issued each cycle by the sequencer. It holds the program counter, memory address register, 16x8 RAM, instruction register, A and B registers, and the adder/subtractor around a single 8-bit bus. It returns the current opcode to the sequencer and exposes architectural state for observation. A side port loads the program into RAM.

## Interface
- No parameters. Widths are fixed: 8-bit data, 4-bit address, 16-word RAM.
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ctrl_word  in  12  control word. Bit 11 HLT, 10 PC_INC, 9 PC_EN, 8 MEM_LOAD (MAR load), 7 MEM_EN, 6 IR_LOAD, 5 IR_EN, 4 A_LOAD, 3 A_EN, 2 B_LOAD, 1 ADDER_SUB, 0 ADDER_EN
- prog_we  in  1  RAM program write enable
- prog_addr  in  4  RAM program write address
- prog_data  in  8  RAM program write data
- opcode  out  4  ir[7:4], to the sequencer
- pc_out  out  4  program counter
- a_out  out  8  A register
- bus_out  out  8  current bus value (combinational)
- carry  out  1  registered carry/no-borrow flag
- zero  out  1  registered zero flag
- halted  out  1  sticky halt status
- bus_conflict  out  1  sticky flag: more than one bus driver was enabled

## Operation
- Bus is combinational and driven by the highest-priority enable: PC_EN gives {4'h0,pc}; MEM_EN gives ram[mar]; IR_EN gives {4'h0,ir[3:0]}; A_EN gives a; ADDER_EN gives sum. With no enable asserted, the bus is 8'h00.
- If two or more of the five enables are asserted, bus_conflict sets on the next edge and stays set until rst. The bus still follows the priority order.
- Adder is combinational: ADDER_SUB=0 gives a+b; ADDER_SUB=1 gives a-b (two's complement). Result is 8 bits, mod 256.
- All loads capture the bus value at the rising edge:
  - MEM_LOAD: mar <= bus[3:0]
  - IR_LOAD: ir <= bus
  - A_LOAD: a <= bus
  - B_LOAD: b <= bus
- PC_INC: pc <= pc+1. It wraps from 15 to 0.
- Same-cycle source and destination use old values. PC_EN with PC_INC puts the old pc on the bus, then pc increments. ADDER_EN with A_LOAD captures old a ± old b.
- Flags update only on edges where A_LOAD && ADDER_EN:
  - add: carry <= bit 8 of a+b
  - sub: carry <= (a >= b), unsigned
  - zero <= (result == 0)
  - Any other A_LOAD leaves both flags unchanged.
- HLT: halted <= 1 at the edge, and it stays set until rst.
- While halted is set, every ctrl_word bit is ignored: no loads, no PC change, no flag change, no conflict update. The bus stays combinational.
- RAM read is asynchronous at address mar. The datapath never writes RAM.
- Program port: prog_we writes ram[prog_addr] <= prog_data at the edge. It is honoured during rst and during halt.
- If MEM_EN reads the address being written in the same cycle, the bus shows the old data.

## Timing
- Reset values after an edge with rst=1:
  - pc, mar, ir, a, b = 0
  - carry = 0, zero = 0, halted = 0, bus_conflict = 0
  - Hence opcode=0, pc_out=0, a_out=0.
- rst overrides ctrl_word in the same cycle. RAM contents are not cleared.
- ctrl_word is sampled once per rising edge. Register effects are visible one cycle after the control word is presented.
- bus_out reacts in the same cycle as ctrl_word.
- Reset asserted mid-instruction aborts it cleanly. The next cycle starts from pc=0 with RAM intact.
- One instruction takes six control words: fetch uses three, execute uses three.

## Test plan
- Basic program. Hold rst and load RAM: 0:09, 1:1A, 2:2B, 3:F0, 9:10, A:14, B:04. Drive the LDA/ADD/SUB/HLT control sequence.
  - Required: a_out = 10, then 24, then 20.
  - After SUB: carry=1, zero=0.
  - At the end: halted=1, pc_out=4, opcode=F.
- Overflow. a=F0, b=20, ADD with A_LOAD. Required: a_out=10, carry=1, zero=0.
- Equal subtract. a=05, b=05, SUB. Required: a_out=00, zero=1, carry=1. Then a=03, b=05, SUB: a_out=FE, carry=0, zero=0.
- Bus conflict. PC_EN and MEM_EN together with pc=3 and ram[mar]=77. Required: bus_out=03 and bus_conflict=1 next cycle. It stays 1 until rst.
- PC wrap. 16 consecutive PC_INC cycles from pc=0. Required: pc_out reads 1..15, then 0.
- Halt and reset. Apply HLT, then A_LOAD with MEM_EN. Required: a_out unchanged, halted=1.
  - Then rst for one cycle. Required: all registers 0, halted=0, RAM unchanged. Re-run the basic program and get the same results.

Source files
------------

// File: rtl/sap1_datapath_if.sv
// Signal bundle between the SAP-1 sequencer/loader and the execution datapath.
// The master side issues control words and program writes; the slave side is
// the datapath, which returns the opcode and its architectural state.
interface sap1_datapath_if;
  logic [11:0] ctrl_word;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [3:0]  pc_out;
  logic [7:0]  a_out;
  logic [7:0]  bus_out;
  logic        carry;
  logic        zero;
  logic        halted;
  logic        bus_conflict;

  modport master (
    output ctrl_word, prog_we, prog_addr, prog_data,
    input  opcode, pc_out, a_out, bus_out, carry, zero, halted, bus_conflict
  );

  modport slave (
    input  ctrl_word, prog_we, prog_addr, prog_data,
    output opcode, pc_out, a_out, bus_out, carry, zero, halted, bus_conflict
  );
endinterface

// File: rtl/sap1_datapath.sv
// SAP-1 execution datapath: PC, MAR, 16x8 RAM, IR, A, B and adder/subtractor
// around a single priority-muxed 8-bit bus. Consumes one 12-bit control word
// per clock; a side port loads the program into RAM.
module sap1_datapath (
  input logic           clk,
  input logic           rst,
  sap1_datapath_if.slave dp
);

  // Control word bit positions
  localparam int unsigned CwHlt     = 11;
  localparam int unsigned CwPcInc   = 10;
  localparam int unsigned CwPcEn    = 9;
  localparam int unsigned CwMemLoad = 8;
  localparam int unsigned CwMemEn   = 7;
  localparam int unsigned CwIrLoad  = 6;
  localparam int unsigned CwIrEn    = 5;
  localparam int unsigned CwALoad   = 4;
  localparam int unsigned CwAEn     = 3;
  localparam int unsigned CwBLoad   = 2;
  localparam int unsigned CwSub     = 1;
  localparam int unsigned CwAddEn   = 0;

  logic [3:0] pc_q;
  logic [3:0] mar_q;
  logic [7:0] ir_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       carry_q;
  logic       zero_q;
  logic       halted_q;
  logic       conflict_q;

  logic [7:0] ram [16];

  logic [11:0] cw;
  logic [7:0]  bus;
  logic [7:0]  b_operand;
  logic [8:0]  sum9;
  logic [7:0]  sum;
  logic [4:0]  bus_en;
  logic        multi_driver;

  assign cw = dp.ctrl_word;

  // Subtraction is a + ~b + 1; bit 8 is then the no-borrow flag (a >= b).
  assign b_operand = cw[CwSub] ? ~b_q : b_q;
  assign sum9      = {1'b0, a_q} + {1'b0, b_operand} + {8'h00, cw[CwSub]};
  assign sum       = sum9[7:0];

  // Two or more bus enables: clearing the lowest set bit leaves something.
  assign bus_en       = {cw[CwPcEn], cw[CwMemEn], cw[CwIrEn], cw[CwAEn], cw[CwAddEn]};
  assign multi_driver = |(bus_en & (bus_en - 5'd1));

  // Bus source selection, highest priority first; idle bus reads zero.
  always_comb begin
    bus = 8'h00;
    if (cw[CwPcEn]) begin
      bus = {4'h0, pc_q};
    end else if (cw[CwMemEn]) begin
      bus = ram[mar_q];
    end else if (cw[CwIrEn]) begin
      bus = {4'h0, ir_q[3:0]};
    end else if (cw[CwAEn]) begin
      bus = a_q;
    end else if (cw[CwAddEn]) begin
      bus = sum;
    end
  end

  // Program port write; RAM is never cleared and ignores reset and halt.
  always_ff @(posedge clk) begin
    if (dp.prog_we) begin
      ram[dp.prog_addr] <= dp.prog_data;
    end
  end

  // Architectural register updates; frozen entirely once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= 4'h0;
      mar_q      <= 4'h0;
      ir_q       <= 8'h00;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      halted_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else if (!halted_q) begin
      if (cw[CwHlt]) begin
        halted_q <= 1'b1;
      end
      if (cw[CwPcInc]) begin
        pc_q <= pc_q + 4'd1;
      end
      if (cw[CwMemLoad]) begin
        mar_q <= bus[3:0];
      end
      if (cw[CwIrLoad]) begin
        ir_q <= bus;
      end
      if (cw[CwALoad]) begin
        a_q <= bus;
      end
      if (cw[CwBLoad]) begin
        b_q <= bus;
      end
      // Flags track only adder results written back into A.
      if (cw[CwALoad] && cw[CwAddEn]) begin
        carry_q <= sum9[8];
        zero_q  <= (sum == 8'h00);
      end
      if (multi_driver) begin
        conflict_q <= 1'b1;
      end
    end
  end

  assign dp.opcode       = ir_q[7:4];
  assign dp.pc_out       = pc_q;
  assign dp.a_out        = a_q;
  assign dp.bus_out      = bus;
  assign dp.carry        = carry_q;
  assign dp.zero         = zero_q;
  assign dp.halted       = halted_q;
  assign dp.bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Scoreboard bench for sap1_datapath: stimulus pushes hand-computed expected
// values into a queue, and a monitor pops and compares them on the falling edge.
module tb_sap1_datapath;

  localparam int SigOpc  = 0;
  localparam int SigPc   = 1;
  localparam int SigA    = 2;
  localparam int SigBus  = 3;
  localparam int SigC    = 4;
  localparam int SigZ    = 5;
  localparam int SigHalt = 6;
  localparam int SigConf = 7;

  typedef struct {
    int         id;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  sap1_datapath_if bus_if ();

  sap1_datapath dut (
    .clk (clk),
    .rst (rst),
    .dp  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  function automatic logic [7:0] observe(input int id);
    case (id)
      SigOpc:  return {4'h0, bus_if.opcode};
      SigPc:   return {4'h0, bus_if.pc_out};
      SigA:    return bus_if.a_out;
      SigBus:  return bus_if.bus_out;
      SigC:    return {7'h00, bus_if.carry};
      SigZ:    return {7'h00, bus_if.zero};
      SigHalt: return {7'h00, bus_if.halted};
      default: return {7'h00, bus_if.bus_conflict};
    endcase
  endfunction

  // Monitor: compare every pending expectation against the settled outputs.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = observe(e.id);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int id, input logic [7:0] v, input string n);
    sb_q.push_back('{id, v, n});
  endtask

  task automatic drive(input logic [11:0] cw);
    bus_if.ctrl_word = cw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [11:0] cw);
    drive(cw);
    step();
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = addr;
    bus_if.prog_data = data;
    tick(12'h000);
    bus_if.prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(12'h000);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    expect_val(SigOpc,  8'h00, {tag, "_opcode"});
    expect_val(SigPc,   8'h00, {tag, "_pc"});
    expect_val(SigA,    8'h00, {tag, "_a"});
    expect_val(SigC,    8'h00, {tag, "_carry"});
    expect_val(SigZ,    8'h00, {tag, "_zero"});
    expect_val(SigHalt, 8'h00, {tag, "_halted"});
    expect_val(SigConf, 8'h00, {tag, "_conflict"});
  endtask

  // Fetch: PC->MAR, PC++, RAM->IR
  task automatic fetch(input logic [3:0] pcv);
    drive(12'h300);
    expect_val(SigBus, {4'h0, pcv}, "fetch_bus_pc");
    step();
    tick(12'h400);
    tick(12'h0C0);
  endtask

  task automatic run_program(input string tag);
    fetch(4'd0);                          // LDA 9
    tick(12'h120);
    tick(12'h090);
    expect_val(SigA, 8'h10, {tag, "_lda_a"});
    tick(12'h000);
    fetch(4'd1);                          // ADD A
    tick(12'h120);
    tick(12'h084);
    tick(12'h011);
    expect_val(SigA, 8'h24, {tag, "_add_a"});
    expect_val(SigC, 8'h00, {tag, "_add_carry"});
    fetch(4'd2);                          // SUB B
    tick(12'h120);
    tick(12'h084);
    tick(12'h013);
    expect_val(SigA, 8'h20, {tag, "_sub_a"});
    expect_val(SigC, 8'h01, {tag, "_sub_carry"});
    expect_val(SigZ, 8'h00, {tag, "_sub_zero"});
    fetch(4'd3);                          // HLT
    tick(12'h800);
    expect_val(SigHalt, 8'h01, {tag, "_halted"});
    expect_val(SigPc,   8'h04, {tag, "_pc"});
    expect_val(SigOpc,  8'h0F, {tag, "_opcode"});
    tick(12'h000);
    tick(12'h000);
    expect_val(SigConf, 8'h00, {tag, "_no_conflict"});
  endtask

  // Load A and B through ram[0] (MAR stays 0 after reset), then add/sub into A.
  task automatic alu_case(input logic [7:0] av, input logic [7:0] bv, input logic sub,
                          input logic [7:0] ea, input logic ec, input logic ez,
                          input string tag);
    prog_write(4'd0, av);
    tick(12'h090);
    expect_val(SigA, av, {tag, "_load_a"});
    prog_write(4'd0, bv);
    tick(12'h084);
    tick(sub ? 12'h013 : 12'h011);
    expect_val(SigA, ea,            {tag, "_a"});
    expect_val(SigC, {7'h00, ec},   {tag, "_carry"});
    expect_val(SigZ, {7'h00, ez},   {tag, "_zero"});
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus_if.ctrl_word = 12'h000;
    bus_if.prog_we   = 1'b0;
    bus_if.prog_addr = 4'h0;
    bus_if.prog_data = 8'h00;

    // Load program while held in reset
    prog_write(4'h0, 8'h09);
    prog_write(4'h1, 8'h1A);
    prog_write(4'h2, 8'h2B);
    prog_write(4'h3, 8'hF0);
    prog_write(4'h9, 8'h10);
    prog_write(4'hA, 8'h14);
    prog_write(4'hB, 8'h04);
    do_reset();
    check_reset("rst0");
    drive(12'h000);
    expect_val(SigBus, 8'h00, "idle_bus");
    step();

    run_program("run1");

    // Halted: control ignored
    tick(12'h800);
    tick(12'h090);
    tick(12'h400);
    expect_val(SigA,    8'h20, "halt_a_held");
    expect_val(SigPc,   8'h04, "halt_pc_held");
    expect_val(SigHalt, 8'h01, "halt_sticky");

    do_reset();
    check_reset("rst1");
    run_program("run2");

    // Reset in the middle of a fetch
    do_reset();
    tick(12'h300);
    tick(12'h400);
    do_reset();
    expect_val(SigPc, 8'h00, "midrst_pc");

    // Arithmetic corners
    alu_case(8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, "ovf");
    alu_case(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1, "eqsub");
    prog_write(4'd0, 8'h33);
    tick(12'h090);                        // plain A load keeps flags
    expect_val(SigA, 8'h33, "plain_a");
    expect_val(SigC, 8'h01, "plain_keep_carry");
    expect_val(SigZ, 8'h01, "plain_keep_zero");
    alu_case(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, "borrow");

    // Bus conflict and same-cycle program write
    do_reset();
    prog_write(4'd0, 8'h77);
    tick(12'h400);
    tick(12'h400);
    tick(12'h400);
    expect_val(SigPc, 8'h03, "conf_pc");
    drive(12'h280);
    expect_val(SigBus, 8'h03, "conf_bus_priority");
    step();
    expect_val(SigConf, 8'h01, "conf_set");
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 4'd0;
    bus_if.prog_data = 8'h55;
    drive(12'h080);
    expect_val(SigBus, 8'h77, "wr_rd_old");
    step();
    bus_if.prog_we = 1'b0;
    drive(12'h080);
    expect_val(SigBus, 8'h55, "wr_rd_new");
    step();
    tick(12'h000);
    expect_val(SigConf, 8'h01, "conf_sticky");
    do_reset();
    expect_val(SigConf, 8'h00, "conf_cleared");

    // PC wrap, plus PC_EN with PC_INC showing the old pc
    for (int i = 1; i <= 16; i++) begin
      tick(12'h400);
      expect_val(SigPc, 8'(i % 16), "pc_wrap");
    end
    drive(12'h600);
    expect_val(SigBus, 8'h00, "pc_en_inc_bus");
    step();
    expect_val(SigPc, 8'h01, "pc_en_inc_pc");

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
